chacha_core: RTL and testbench

Iterative, parametrised ChaCha block-function core. It accepts one 256-bit key, 32-bit block counter and 96-bit nonce per transaction. It runs a configurable number of rounds using 1, 2 or 4 quarter-round lanes per cycle, then adds the initial state back in (feed-forward) to produce one 512-bit keystream block. The core sits between the key/nonce scheduler and the keystream XOR stage, with valid/ready handshakes on both sides.

---
 rtl/chacha_core.sv | 165 ++++++++++++++++
 tb/tb_chacha_core.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/chacha_core.sv
// Iterative ChaCha block function: ROUNDS rounds at QR_LANES quarter-rounds per cycle,
// followed by feed-forward of the initial state into a held 512-bit keystream block.
module chacha_core #(
    parameter int ROUNDS   = 20,
    parameter int QR_LANES = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [255:0] key,
    input  logic [31:0]  counter,
    input  logic [95:0]  nonce,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [511:0] out_block,
    output logic         busy
);

    localparam int STEPS_PER_ROUND = (QR_LANES > 0) ? 4 / QR_LANES : 1;
    localparam int STEPS           = ROUNDS * STEPS_PER_ROUND;
    localparam int STEP_W          = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(STEPS - 1);

    if ((ROUNDS < 2) || ((ROUNDS % 2) != 0)) begin : g_bad_rounds
        $error("chacha_core: ROUNDS must be even and at least 2");
    end
    if (!((QR_LANES == 1) || (QR_LANES == 2) || (QR_LANES == 4))) begin : g_bad_lanes
        $error("chacha_core: QR_LANES must be 1, 2 or 4");
    end

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ROUND,
        ST_FINAL,
        ST_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [STEP_W-1:0]   step_q, step_d;
    logic [15:0][31:0]   work_q, work_d;
    logic [15:0][31:0]   init_q, init_d;
    logic [511:0]        out_block_q, out_block_d;

    logic [15:0][31:0]   s0;
    logic [15:0][31:0]   round_work;
    logic [511:0]        final_block;
    logic [31:0]         step_ext;
    logic                diag_round;
    logic [1:0]          qr_base;
    logic [1:0]          lane_qr;
    logic [127:0]        lane_out;

    function automatic logic [31:0] rotl(input logic [31:0] x, input int n);
        return (x << n) | (x >> (32 - n));
    endfunction

    function automatic logic [127:0] quarter_round(input logic [31:0] a_in,
                                                   input logic [31:0] b_in,
                                                   input logic [31:0] c_in,
                                                   input logic [31:0] d_in);
        logic [31:0] a, b, c, d;
        a = a_in; b = b_in; c = c_in; d = d_in;
        a = a + b; d = rotl(d ^ a, 16);
        c = c + d; b = rotl(b ^ c, 12);
        a = a + b; d = rotl(d ^ a, 8);
        c = c + d; b = rotl(b ^ c, 7);
        return {a, b, c, d};
    endfunction

    // Word index of row `row` for quarter-round `qr`; diagonal rounds rotate the column by the row.
    function automatic logic [3:0] qr_index(input logic [1:0] qr, input logic diag,
                                            input logic [1:0] row);
        logic [1:0] col;
        col = diag ? qr + row : qr;
        return {row, col};
    endfunction

    assign s0 = {nonce, counter, key,
                 32'h6b206574, 32'h79622d32, 32'h3320646e, 32'h61707865};

    for (genvar i = 0; i < 16; i++) begin : g_feed_forward
        assign final_block[32*i +: 32] = work_q[i] + init_q[i];
    end

    // One step applies QR_LANES consecutive quarter-rounds of the current round.
    always_comb begin
        step_ext   = 32'(step_q);
        diag_round = ((step_ext / 32'(STEPS_PER_ROUND)) % 32'd2) != 32'd0;
        qr_base    = 2'((step_ext % 32'(STEPS_PER_ROUND)) * 32'(QR_LANES));
        round_work = work_q;
        lane_qr    = '0;
        lane_out   = '0;
        for (int l = 0; l < QR_LANES; l++) begin
            lane_qr  = qr_base + 2'(l);
            lane_out = quarter_round(work_q[qr_index(lane_qr, diag_round, 2'd0)],
                                     work_q[qr_index(lane_qr, diag_round, 2'd1)],
                                     work_q[qr_index(lane_qr, diag_round, 2'd2)],
                                     work_q[qr_index(lane_qr, diag_round, 2'd3)]);
            round_work[qr_index(lane_qr, diag_round, 2'd0)] = lane_out[127:96];
            round_work[qr_index(lane_qr, diag_round, 2'd1)] = lane_out[95:64];
            round_work[qr_index(lane_qr, diag_round, 2'd2)] = lane_out[63:32];
            round_work[qr_index(lane_qr, diag_round, 2'd3)] = lane_out[31:0];
        end
    end

    always_comb begin
        state_d     = state_q;
        step_d      = step_q;
        work_d      = work_q;
        init_d      = init_q;
        out_block_d = out_block_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    work_d  = s0;
                    init_d  = s0;
                    step_d  = '0;
                    state_d = ST_ROUND;
                end
            end
            ST_ROUND: begin
                work_d = round_work;
                if (step_q == LAST_STEP) begin
                    step_d  = '0;
                    state_d = ST_FINAL;
                end else begin
                    step_d = step_q + STEP_W'(1);
                end
            end
            ST_FINAL: begin
                out_block_d = final_block;
                state_d     = ST_DONE;
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            step_q      <= '0;
            work_q      <= '0;
            init_q      <= '0;
            out_block_q <= '0;
        end else begin
            state_q     <= state_d;
            step_q      <= step_d;
            work_q      <= work_d;
            init_q      <= init_d;
            out_block_q <= out_block_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign busy      = (state_q == ST_ROUND) || (state_q == ST_FINAL);
    assign out_valid = (state_q == ST_DONE);
    assign out_block = out_block_q;

endmodule

// File: tb/tb_chacha_core.sv
// Bench for chacha_core: five configurations checked every cycle against a
// transaction-level ChaCha model, plus RFC 8439 literal vectors.
module tb_chacha_core;

    localparam int NDUT = 5;

    logic         clk;
    logic         rst       [NDUT];
    logic         in_valid  [NDUT];
    logic         in_ready  [NDUT];
    logic [255:0] key       [NDUT];
    logic [31:0]  counter   [NDUT];
    logic [95:0]  nonce     [NDUT];
    logic         out_valid [NDUT];
    logic         out_ready [NDUT];
    logic [511:0] out_block [NDUT];
    logic         busy      [NDUT];

    int checks = 0;
    int errors = 0;

    int           m_phase [NDUT];
    int           m_count [NDUT];
    int           m_acc   [NDUT];
    int           m_del   [NDUT];
    int           dut_del [NDUT];
    logic [511:0] m_pend  [NDUT];
    logic [511:0] m_out   [NDUT];
    logic [2:0]   exp_ctrl;
    logic [2:0]   got_ctrl;

    function automatic int cfg_rounds(int g);
        return (g == 3) ? 8 : (g == 4) ? 12 : 20;
    endfunction

    function automatic int cfg_lanes(int g);
        return (g == 0) ? 4 : (g == 1) ? 2 : (g == 2) ? 1 : (g == 3) ? 2 : 1;
    endfunction

    function automatic int cfg_latency(int g);
        return cfg_rounds(g) * 4 / cfg_lanes(g) + 1;
    endfunction

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        chacha_core #(
            .ROUNDS   (cfg_rounds(g)),
            .QR_LANES (cfg_lanes(g))
        ) u_dut (
            .clk       (clk),
            .rst       (rst[g]),
            .in_valid  (in_valid[g]),
            .in_ready  (in_ready[g]),
            .key       (key[g]),
            .counter   (counter[g]),
            .nonce     (nonce[g]),
            .out_valid (out_valid[g]),
            .out_ready (out_ready[g]),
            .out_block (out_block[g]),
            .busy      (busy[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] ref_rol(input logic [31:0] x, input int n);
        logic [63:0] t;
        t = {x, x} << n;
        return t[63:32];
    endfunction

    function automatic logic [511:0] ref_qr(input logic [511:0] st, input int a, input int b,
                                            input int c, input int d);
        logic [31:0] va, vb, vc, vd;
        va = st[32*a +: 32]; vb = st[32*b +: 32]; vc = st[32*c +: 32]; vd = st[32*d +: 32];
        va = va + vb; vd = ref_rol(vd ^ va, 16);
        vc = vc + vd; vb = ref_rol(vb ^ vc, 12);
        va = va + vb; vd = ref_rol(vd ^ va, 8);
        vc = vc + vd; vb = ref_rol(vb ^ vc, 7);
        st[32*a +: 32] = va; st[32*b +: 32] = vb; st[32*c +: 32] = vc; st[32*d +: 32] = vd;
        return st;
    endfunction

    function automatic logic [511:0] chacha_ref(input logic [255:0] k, input logic [31:0] ctr,
                                                input logic [95:0] n, input int rounds);
        logic [511:0] s, x;
        s = {n, ctr, k, 32'h6b206574, 32'h79622d32, 32'h3320646e, 32'h61707865};
        x = s;
        for (int r = 0; r < rounds; r += 2) begin
            x = ref_qr(x, 0, 4, 8, 12);
            x = ref_qr(x, 1, 5, 9, 13);
            x = ref_qr(x, 2, 6, 10, 14);
            x = ref_qr(x, 3, 7, 11, 15);
            x = ref_qr(x, 0, 5, 10, 15);
            x = ref_qr(x, 1, 6, 11, 12);
            x = ref_qr(x, 2, 7, 8, 13);
            x = ref_qr(x, 3, 4, 9, 14);
        end
        for (int i = 0; i < 16; i++) begin
            x[32*i +: 32] = x[32*i +: 32] + s[32*i +: 32];
        end
        return x;
    endfunction

    // Transaction model: idle -> computing for the spec latency -> holding until out_ready.
    always @(posedge clk) begin
        for (int g = 0; g < NDUT; g++) begin
            if (rst[g]) begin
                m_phase[g] = 0;
                m_count[g] = 0;
                m_out[g]   = '0;
            end else begin
                case (m_phase[g])
                    0: begin
                        if (in_valid[g]) begin
                            m_pend[g]  = chacha_ref(key[g], counter[g], nonce[g], cfg_rounds(g));
                            m_phase[g] = 1;
                            m_count[g] = 0;
                            m_acc[g]++;
                        end
                    end
                    1: begin
                        m_count[g]++;
                        if (m_count[g] == cfg_latency(g)) begin
                            m_phase[g] = 2;
                            m_out[g]   = m_pend[g];
                        end
                    end
                    default: begin
                        if (out_ready[g]) begin
                            m_phase[g] = 0;
                            m_del[g]++;
                        end
                    end
                endcase
            end
        end
    end

    always @(negedge clk) begin
        for (int g = 0; g < NDUT; g++) begin
            if (!rst[g]) begin
                exp_ctrl = {m_phase[g] == 0, m_phase[g] == 1, m_phase[g] == 2};
                got_ctrl = {in_ready[g], busy[g], out_valid[g]};
                checks++;
                if (got_ctrl !== exp_ctrl) begin
                    errors++;
                    $display("[TB] FAIL ctrl dut=%0d t=%0t in_ready/busy/out_valid got=%b want=%b",
                             g, $time, got_ctrl, exp_ctrl);
                end
                checks++;
                if (out_block[g] !== m_out[g]) begin
                    errors++;
                    $display("[TB] FAIL block dut=%0d t=%0t got=%h want=%h",
                             g, $time, out_block[g], m_out[g]);
                end
                if (out_valid[g] && out_ready[g]) dut_del[g]++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_val(input string name, input int g, input logic [63:0] got,
                             input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("[TB] FAIL %s dut=%0d t=%0t got=%h want=%h", name, g, $time, got, want);
        end
    endtask

    task automatic run_txn(input int g, input logic [255:0] k, input logic [31:0] ctr,
                           input logic [95:0] n, output int lat);
        int w;
        key[g] = k; counter[g] = ctr; nonce[g] = n; in_valid[g] = 1'b1;
        w = 0;
        while (!in_ready[g] && w < 200) begin
            tick();
            w++;
        end
        check_val("accept_ready", g, 64'(in_ready[g]), 64'd1);
        tick();
        in_valid[g] = 1'b0; key[g] = ~k; counter[g] = ~ctr; nonce[g] = ~n;
        lat = 0;
        while (!out_valid[g] && lat < 500) begin
            tick();
            lat++;
        end
    endtask

    task automatic release_block(input int g);
        out_ready[g] = 1'b1;
        tick();
        out_ready[g] = 1'b0;
        check_val("ready_after_release", g, 64'(in_ready[g]), 64'd1);
    endtask

    task automatic randomize_inputs(input int g);
        for (int i = 0; i < 8; i++) key[g][32*i +: 32] = $urandom();
        for (int i = 0; i < 3; i++) nonce[g][32*i +: 32] = $urandom();
        counter[g] = $urandom();
    endtask

    task automatic run_random(input int g, input int n);
        int budget;
        budget = 0;
        while ((m_del[g] < n) && (budget < 30000)) begin
            randomize_inputs(g);
            in_valid[g]  = (m_acc[g] < n) && ($urandom_range(3) != 0);
            out_ready[g] = ($urandom_range(2) != 0);
            tick();
            budget++;
        end
        in_valid[g]  = 1'b0;
        out_ready[g] = 1'b0;
        check_val("random_no_timeout", g, 64'(budget < 30000), 64'd1);
        check_val("random_accepted", g, 64'(m_acc[g]), 64'(n));
        check_val("random_delivered", g, 64'(dut_del[g]), 64'(n));
    endtask

    logic [255:0] rfc_key;
    logic [95:0]  rfc_nonce;
    int           lat;
    int           lat_want [3] = '{21, 41, 81};

    initial begin
        for (int g = 0; g < NDUT; g++) begin
            rst[g] = 1'b1; in_valid[g] = 1'b0; out_ready[g] = 1'b0;
            key[g] = '0; counter[g] = '0; nonce[g] = '0;
        end
        for (int i = 0; i < 32; i++) rfc_key[8*i +: 8] = 8'(i);
        rfc_nonce = {32'h00000000, 32'h4a000000, 32'h09000000};

        repeat (3) tick();
        for (int g = 0; g < NDUT; g++) begin
            check_val("reset_ctrl", g, 64'({in_ready[g], busy[g], out_valid[g]}), 64'b100);
            check_val("reset_block_zero", g, 64'(|out_block[g]), 64'd0);
        end
        for (int g = 0; g < NDUT; g++) rst[g] = 1'b0;
        tick();

        for (int g = 0; g < 3; g++) begin
            run_txn(g, rfc_key, 32'd1, rfc_nonce, lat);
            check_val("rfc_latency", g, 64'(lat), 64'(lat_want[g]));
            check_val("rfc_w1w0", g, out_block[g][63:0], 64'h15593bd1_e4e7f110);
            check_val("rfc_w3w2", g, out_block[g][127:64], 64'hc47120a3_1fdd0f50);
            release_block(g);
        end

        run_txn(0, '0, 32'd0, '0, lat);
        check_val("zero_w1w0", 0, out_block[0][63:0], 64'h903df1a0_ade0b876);
        release_block(0);

        run_txn(0, rfc_key, 32'd1, rfc_nonce, lat);
        for (int c = 0; c < 10; c++) begin
            in_valid[0] = 1'b1;
            randomize_inputs(0);
            tick();
            check_val("bp_ctrl", 0, 64'({in_ready[0], out_valid[0]}), 64'b01);
            check_val("bp_hold", 0, out_block[0][63:0], 64'h15593bd1_e4e7f110);
        end
        in_valid[0] = 1'b0;
        release_block(0);

        key[0] = rfc_key; counter[0] = 32'd1; nonce[0] = rfc_nonce; in_valid[0] = 1'b1;
        tick();
        in_valid[0] = 1'b0;
        repeat (5) tick();
        check_val("busy_before_rst", 0, 64'(busy[0]), 64'd1);
        rst[0] = 1'b1;
        #1;
        check_val("rst_ctrl", 0, 64'({in_ready[0], busy[0], out_valid[0]}), 64'b100);
        check_val("rst_block_zero", 0, 64'(|out_block[0]), 64'd0);
        tick();
        rst[0] = 1'b0;
        run_txn(0, rfc_key, 32'd1, rfc_nonce, lat);
        check_val("post_rst_latency", 0, 64'(lat), 64'd21);
        check_val("post_rst_w1w0", 0, out_block[0][63:0], 64'h15593bd1_e4e7f110);
        release_block(0);

        run_random(3, 100);
        run_random(4, 100);

        repeat (2) tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
